// File: rtl/vscale_hasti_arbiter.sv
// Two-master HASTI (AHB-lite) arbiter: m0 (imem bridge) and m1 (dmem bridge)
// share one slave port. Arbitrates each address phase, tracks the data-phase
// owner, and buffers a completed response for a master that lost the next
// address phase so pipelined data is never dropped.
module vscale_hasti_arbiter #(
  parameter int unsigned ROUND_ROBIN       = 0,
  parameter int unsigned HASTI_ADDR_WIDTH  = 32,
  parameter int unsigned HASTI_BUS_WIDTH   = 32,
  parameter int unsigned HASTI_SIZE_WIDTH  = 3,
  parameter int unsigned HASTI_BURST_WIDTH = 3,
  parameter int unsigned HASTI_PROT_WIDTH  = 4,
  parameter int unsigned HASTI_TRANS_WIDTH = 2,
  parameter int unsigned HASTI_RESP_WIDTH  = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  // master 0 (imem bridge)
  input  logic [HASTI_ADDR_WIDTH-1:0]  m0_haddr,
  input  logic                         m0_hwrite,
  input  logic [HASTI_SIZE_WIDTH-1:0]  m0_hsize,
  input  logic [HASTI_BURST_WIDTH-1:0] m0_hburst,
  input  logic                         m0_hmastlock,
  input  logic [HASTI_PROT_WIDTH-1:0]  m0_hprot,
  input  logic [HASTI_TRANS_WIDTH-1:0] m0_htrans,
  input  logic [HASTI_BUS_WIDTH-1:0]   m0_hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]   m0_hrdata,
  output logic                         m0_hready,
  output logic [HASTI_RESP_WIDTH-1:0]  m0_hresp,
  // master 1 (dmem bridge)
  input  logic [HASTI_ADDR_WIDTH-1:0]  m1_haddr,
  input  logic                         m1_hwrite,
  input  logic [HASTI_SIZE_WIDTH-1:0]  m1_hsize,
  input  logic [HASTI_BURST_WIDTH-1:0] m1_hburst,
  input  logic                         m1_hmastlock,
  input  logic [HASTI_PROT_WIDTH-1:0]  m1_hprot,
  input  logic [HASTI_TRANS_WIDTH-1:0] m1_htrans,
  input  logic [HASTI_BUS_WIDTH-1:0]   m1_hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]   m1_hrdata,
  output logic                         m1_hready,
  output logic [HASTI_RESP_WIDTH-1:0]  m1_hresp,
  // shared slave port
  output logic [HASTI_ADDR_WIDTH-1:0]  s_haddr,
  output logic                         s_hwrite,
  output logic [HASTI_SIZE_WIDTH-1:0]  s_hsize,
  output logic [HASTI_BURST_WIDTH-1:0] s_hburst,
  output logic                         s_hmastlock,
  output logic [HASTI_PROT_WIDTH-1:0]  s_hprot,
  output logic [HASTI_TRANS_WIDTH-1:0] s_htrans,
  output logic [HASTI_BUS_WIDTH-1:0]   s_hwdata,
  input  logic [HASTI_BUS_WIDTH-1:0]   s_hrdata,
  input  logic                         s_hready,
  input  logic [HASTI_RESP_WIDTH-1:0]  s_hresp
);

  localparam logic [HASTI_TRANS_WIDTH-1:0] HTRANS_IDLE = '0;
  localparam logic [HASTI_RESP_WIDTH-1:0]  HRESP_OKAY  = '0;

  // Arbitration state
  logic gnt_q;
  logic last_q;
  // Data-phase tracking
  logic dp_vld;
  logic dp_own;
  logic dp_wr;
  // Per-master response buffers
  logic                        pend_0;
  logic                        pend_1;
  logic [HASTI_BUS_WIDTH-1:0]  buf_rdata_0;
  logic [HASTI_BUS_WIDTH-1:0]  buf_rdata_1;
  logic [HASTI_RESP_WIDTH-1:0] buf_resp_0;
  logic [HASTI_RESP_WIDTH-1:0] buf_resp_1;

  logic req_0;
  logic req_1;
  logic req_any;
  logic req_win;
  logic gnt;

  assign req_0   = m0_htrans[HASTI_TRANS_WIDTH-1];
  assign req_1   = m1_htrans[HASTI_TRANS_WIDTH-1];
  assign req_any = req_0 | req_1;
  assign req_win = gnt ? req_1 : req_0;

  // Pick the address-phase winner; the grant is frozen while the slave stalls.
  always_comb begin
    gnt = gnt_q;
    if (s_hready) begin
      if (req_0 && req_1) begin
        gnt = (ROUND_ROBIN != 0) ? ~last_q : 1'b1;
      end else if (req_1) begin
        gnt = 1'b1;
      end else if (req_0) begin
        gnt = 1'b0;
      end
    end
  end

  // Route the winner's address-phase signals to the slave.
  always_comb begin
    s_haddr     = m0_haddr;
    s_hwrite    = m0_hwrite;
    s_hsize     = m0_hsize;
    s_hburst    = m0_hburst;
    s_hmastlock = m0_hmastlock;
    s_hprot     = m0_hprot;
    s_htrans    = m0_htrans;
    if (gnt) begin
      s_haddr     = m1_haddr;
      s_hwrite    = m1_hwrite;
      s_hsize     = m1_hsize;
      s_hburst    = m1_hburst;
      s_hmastlock = m1_hmastlock;
      s_hprot     = m1_hprot;
      s_htrans    = m1_htrans;
    end
    if (!req_win) begin
      s_htrans = HTRANS_IDLE;
    end
  end

  // Write data follows the data-phase owner with no added latency.
  always_comb begin
    s_hwdata = dp_own ? m1_hwdata : m0_hwdata;
  end

  // Master 0 ready/response selection.
  always_comb begin
    m0_hready = 1'b1;
    m0_hresp  = HRESP_OKAY;
    m0_hrdata = s_hrdata;
    if (req_0 && gnt) begin
      m0_hready = 1'b0;
    end else if (dp_vld && !dp_own) begin
      m0_hready = s_hready;
      m0_hresp  = s_hresp;
    end else if (pend_0 && !gnt) begin
      m0_hready = s_hready;
      m0_hresp  = buf_resp_0;
      m0_hrdata = buf_rdata_0;
    end else if (req_0) begin
      // Winning address phase behind another master's stalled data phase.
      m0_hready = s_hready;
    end
  end

  // Master 1 ready/response selection.
  always_comb begin
    m1_hready = 1'b1;
    m1_hresp  = HRESP_OKAY;
    m1_hrdata = s_hrdata;
    if (req_1 && !gnt) begin
      m1_hready = 1'b0;
    end else if (dp_vld && dp_own) begin
      m1_hready = s_hready;
      m1_hresp  = s_hresp;
    end else if (pend_1 && gnt) begin
      m1_hready = s_hready;
      m1_hresp  = buf_resp_1;
      m1_hrdata = buf_rdata_1;
    end else if (req_1) begin
      // Winning address phase behind another master's stalled data phase.
      m1_hready = s_hready;
    end
  end

  // Grant and data-phase bookkeeping advance only when the slave is ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q  <= 1'b0;
      last_q <= 1'b0;
      dp_vld <= 1'b0;
      dp_own <= 1'b0;
      dp_wr  <= 1'b0;
    end else if (s_hready) begin
      gnt_q <= gnt;
      if (req_any) begin
        last_q <= gnt;
      end
      dp_vld <= req_any;
      dp_own <= gnt;
      dp_wr  <= gnt ? m1_hwrite : m0_hwrite;
    end
  end

  // Master 0 buffer: capture a completing response m0 cannot take, replay it when granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_0      <= 1'b0;
      buf_rdata_0 <= '0;
      buf_resp_0  <= '0;
    end else if (s_hready && dp_vld && !dp_own && req_0 && gnt) begin
      pend_0     <= 1'b1;
      buf_resp_0 <= s_hresp;
      if (!dp_wr) begin
        buf_rdata_0 <= s_hrdata;
      end
    end else if (s_hready && !gnt) begin
      pend_0 <= 1'b0;
    end
  end

  // Master 1 buffer: capture a completing response m1 cannot take, replay it when granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_1      <= 1'b0;
      buf_rdata_1 <= '0;
      buf_resp_1  <= '0;
    end else if (s_hready && dp_vld && dp_own && req_1 && !gnt) begin
      pend_1     <= 1'b1;
      buf_resp_1 <= s_hresp;
      if (!dp_wr) begin
        buf_rdata_1 <= s_hrdata;
      end
    end else if (s_hready && gnt) begin
      pend_1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// Directed bench for vscale_hasti_arbiter: a fixed-priority instance (dut) and a
// round-robin instance (dut_rr) share all inputs; each task checks one scenario.
module tb_vscale_hasti_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata;
  logic        m0_hwrite, m1_hwrite, m0_hmastlock, m1_hmastlock;
  logic [2:0]  m0_hsize, m1_hsize, m0_hburst, m1_hburst;
  logic [3:0]  m0_hprot, m1_hprot;
  logic [1:0]  m0_htrans, m1_htrans;
  logic [31:0] s_hrdata;
  logic        s_hready;
  logic        s_hresp;

  // fixed-priority instance outputs
  logic [31:0] m0_hrdata, m1_hrdata, s_haddr, s_hwdata;
  logic        m0_hready, m1_hready, m0_hresp, m1_hresp, s_hwrite, s_hmastlock;
  logic [2:0]  s_hsize, s_hburst;
  logic [3:0]  s_hprot;
  logic [1:0]  s_htrans;
  // round-robin instance outputs
  logic [31:0] r_m0_hrdata, r_m1_hrdata, r_s_haddr, r_s_hwdata;
  logic        r_m0_hready, r_m1_hready, r_m0_hresp, r_m1_hresp, r_s_hwrite, r_s_hmastlock;
  logic [2:0]  r_s_hsize, r_s_hburst;
  logic [3:0]  r_s_hprot;
  logic [1:0]  r_s_htrans;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vscale_hasti_arbiter #(.ROUND_ROBIN(0)) dut (
    .clk(clk), .reset(reset),
    .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize), .m0_hburst(m0_hburst),
    .m0_hmastlock(m0_hmastlock), .m0_hprot(m0_hprot), .m0_htrans(m0_htrans),
    .m0_hwdata(m0_hwdata), .m0_hrdata(m0_hrdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp),
    .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize), .m1_hburst(m1_hburst),
    .m1_hmastlock(m1_hmastlock), .m1_hprot(m1_hprot), .m1_htrans(m1_htrans),
    .m1_hwdata(m1_hwdata), .m1_hrdata(m1_hrdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp),
    .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst),
    .s_hmastlock(s_hmastlock), .s_hprot(s_hprot), .s_htrans(s_htrans), .s_hwdata(s_hwdata),
    .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
  );

  vscale_hasti_arbiter #(.ROUND_ROBIN(1)) dut_rr (
    .clk(clk), .reset(reset),
    .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize), .m0_hburst(m0_hburst),
    .m0_hmastlock(m0_hmastlock), .m0_hprot(m0_hprot), .m0_htrans(m0_htrans),
    .m0_hwdata(m0_hwdata), .m0_hrdata(r_m0_hrdata), .m0_hready(r_m0_hready),
    .m0_hresp(r_m0_hresp),
    .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize), .m1_hburst(m1_hburst),
    .m1_hmastlock(m1_hmastlock), .m1_hprot(m1_hprot), .m1_htrans(m1_htrans),
    .m1_hwdata(m1_hwdata), .m1_hrdata(r_m1_hrdata), .m1_hready(r_m1_hready),
    .m1_hresp(r_m1_hresp),
    .s_haddr(r_s_haddr), .s_hwrite(r_s_hwrite), .s_hsize(r_s_hsize), .s_hburst(r_s_hburst),
    .s_hmastlock(r_s_hmastlock), .s_hprot(r_s_hprot), .s_htrans(r_s_htrans),
    .s_hwdata(r_s_hwdata),
    .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
  );

  // Advance to just after the next active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_haddr = '0; m1_haddr = '0; m0_hwdata = '0; m1_hwdata = '0;
    m0_hwrite = 1'b0; m1_hwrite = 1'b0; m0_hmastlock = 1'b0; m1_hmastlock = 1'b0;
    m0_hsize = 3'd2; m1_hsize = 3'd2; m0_hburst = 3'd0; m1_hburst = 3'd0;
    m0_hprot = 4'b0011; m1_hprot = 4'b0011; m0_htrans = 2'b00; m1_htrans = 2'b00;
    s_hrdata = '0; s_hready = 1'b1; s_hresp = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #3;
    n_cmp++; if (s_htrans !== 2'b00) begin n_bad++; $display("FAIL rst_htrans: got %h want 0", s_htrans); end
    n_cmp++; if (m0_hready !== 1'b1) begin n_bad++; $display("FAIL rst_m0_hready: got %b want 1", m0_hready); end
    n_cmp++; if (m1_hready !== 1'b1) begin n_bad++; $display("FAIL rst_m1_hready: got %b want 1", m1_hready); end
    n_cmp++; if (m0_hresp !== 1'b0) begin n_bad++; $display("FAIL rst_m0_hresp: got %b want 0", m0_hresp); end
    n_cmp++; if (dut.pend_0 !== 1'b0 || dut.pend_1 !== 1'b0) begin n_bad++; $display("FAIL rst_pend: got %b%b want 00", dut.pend_1, dut.pend_0); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    m1_htrans = 2'b10; m1_haddr = 32'h100;
    #1;
    n_cmp++; if (s_haddr !== 32'h100) begin n_bad++; $display("FAIL single_haddr: got %h want 100", s_haddr); end
    n_cmp++; if (s_htrans !== 2'b10) begin n_bad++; $display("FAIL single_htrans: got %h want 2", s_htrans); end
    n_cmp++; if (m1_hready !== 1'b1) begin n_bad++; $display("FAIL single_hready_a: got %b want 1", m1_hready); end
    step();
    m1_htrans = 2'b00; s_hrdata = 32'hCAFE0001;
    #1;
    n_cmp++; if (m1_hready !== 1'b1) begin n_bad++; $display("FAIL single_hready_d: got %b want 1", m1_hready); end
    n_cmp++; if (m1_hrdata !== 32'hCAFE0001) begin n_bad++; $display("FAIL single_rdata: got %h want cafe0001", m1_hrdata); end
    n_cmp++; if (s_htrans !== 2'b00) begin n_bad++; $display("FAIL single_idle: got %h want 0", s_htrans); end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    m0_htrans = 2'b10; m0_haddr = 32'h10;
    m1_htrans = 2'b10;
    for (int i = 0; i < 3; i++) begin
      m1_haddr = 32'h20 + 32'(4 * i);
      s_hrdata = 32'hA000 + 32'(i);
      #1;
      n_cmp++; if (s_haddr !== 32'h20 + 32'(4 * i)) begin n_bad++; $display("FAIL fix_haddr%0d: got %h want %h", i, s_haddr, 32'h20 + 32'(4 * i)); end
      n_cmp++; if (m0_hready !== 1'b0) begin n_bad++; $display("FAIL fix_m0_stall%0d: got %b want 0", i, m0_hready); end
      n_cmp++; if (m1_hready !== 1'b1) begin n_bad++; $display("FAIL fix_m1_ready%0d: got %b want 1", i, m1_hready); end
      step();
    end
    m1_htrans = 2'b00; s_hrdata = 32'hA003;
    #1;
    n_cmp++; if (s_haddr !== 32'h10) begin n_bad++; $display("FAIL fix_m0_haddr: got %h want 10", s_haddr); end
    n_cmp++; if (m0_hready !== 1'b1) begin n_bad++; $display("FAIL fix_m0_go: got %b want 1", m0_hready); end
    n_cmp++; if (m1_hrdata !== 32'hA003) begin n_bad++; $display("FAIL fix_m1_last: got %h want a003", m1_hrdata); end
    step();
    idle_inputs();
  endtask

  task automatic test_round_robin();
    do_reset();
    // t0: both request; last_q=0 so m1 wins
    m0_htrans = 2'b10; m0_haddr = 32'h10;
    m1_htrans = 2'b10; m1_haddr = 32'h20;
    #1;
    n_cmp++; if (r_s_haddr !== 32'h20) begin n_bad++; $display("FAIL rr_t0_haddr: got %h want 20", r_s_haddr); end
    n_cmp++; if (r_m0_hready !== 1'b0) begin n_bad++; $display("FAIL rr_t0_m0: got %b want 0", r_m0_hready); end
    step();
    // t1: m1 data D1 completes but m0 wins; D1 goes to m1's buffer
    m1_haddr = 32'h24; s_hrdata = 32'hD1;
    #1;
    n_cmp++; if (r_s_haddr !== 32'h10) begin n_bad++; $display("FAIL rr_t1_haddr: got %h want 10", r_s_haddr); end
    n_cmp++; if (r_m0_hready !== 1'b1) begin n_bad++; $display("FAIL rr_t1_m0: got %b want 1", r_m0_hready); end
    n_cmp++; if (r_m1_hready !== 1'b0) begin n_bad++; $display("FAIL rr_t1_m1: got %b want 0", r_m1_hready); end
    step();
    // t2: m1 wins, gets D1 from buffer; m0 data D0 buffered
    m0_haddr = 32'h14; s_hrdata = 32'hD0;
    #1;
    n_cmp++; if (r_s_haddr !== 32'h24) begin n_bad++; $display("FAIL rr_t2_haddr: got %h want 24", r_s_haddr); end
    n_cmp++; if (r_m1_hready !== 1'b1) begin n_bad++; $display("FAIL rr_t2_m1: got %b want 1", r_m1_hready); end
    n_cmp++; if (r_m1_hrdata !== 32'hD1) begin n_bad++; $display("FAIL rr_t2_buf1: got %h want d1", r_m1_hrdata); end
    step();
    // t3: m0 wins, gets D0 from buffer; m1 data D2 buffered
    m1_haddr = 32'h28; s_hrdata = 32'hD2;
    #1;
    n_cmp++; if (r_s_haddr !== 32'h14) begin n_bad++; $display("FAIL rr_t3_haddr: got %h want 14", r_s_haddr); end
    n_cmp++; if (r_m0_hrdata !== 32'hD0) begin n_bad++; $display("FAIL rr_t3_buf0: got %h want d0", r_m0_hrdata); end
    n_cmp++; if (r_m1_hready !== 1'b0) begin n_bad++; $display("FAIL rr_t3_m1: got %b want 0", r_m1_hready); end
    step();
    // t4: m0 done requesting; m1 alone, replays D2 while m0 takes live D3
    m0_htrans = 2'b00; s_hrdata = 32'hD3;
    #1;
    n_cmp++; if (r_s_haddr !== 32'h28) begin n_bad++; $display("FAIL rr_t4_haddr: got %h want 28", r_s_haddr); end
    n_cmp++; if (r_m1_hrdata !== 32'hD2) begin n_bad++; $display("FAIL rr_t4_buf1: got %h want d2", r_m1_hrdata); end
    n_cmp++; if (r_m0_hrdata !== 32'hD3) begin n_bad++; $display("FAIL rr_t4_m0: got %h want d3", r_m0_hrdata); end
    step();
    // t5: m1 takes live D4, buffer drained
    m1_htrans = 2'b00; s_hrdata = 32'hD4;
    #1;
    n_cmp++; if (r_m1_hrdata !== 32'hD4) begin n_bad++; $display("FAIL rr_t5_m1: got %h want d4", r_m1_hrdata); end
    n_cmp++; if (dut_rr.pend_1 !== 1'b0) begin n_bad++; $display("FAIL rr_t5_pend1: got %b want 0", dut_rr.pend_1); end
    step();
    idle_inputs();
  endtask

  task automatic test_wait_write();
    do_reset();
    m1_htrans = 2'b10; m1_haddr = 32'h200; m1_hwrite = 1'b1;
    #1;
    n_cmp++; if (s_haddr !== 32'h200 || s_hwrite !== 1'b1) begin n_bad++; $display("FAIL ww_addr: got %h/%b want 200/1", s_haddr, s_hwrite); end
    step();
    // data phase with two wait states; next address 0x204 must stay on the bus
    m1_haddr = 32'h204; m1_hwdata = 32'hDEADBEEF; s_hready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (m1_hready !== 1'b0) begin n_bad++; $display("FAIL ww_wait%0d: got %b want 0", i, m1_hready); end
      n_cmp++; if (s_hwdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ww_wdata%0d: got %h want deadbeef", i, s_hwdata); end
      n_cmp++; if (s_haddr !== 32'h204) begin n_bad++; $display("FAIL ww_hold%0d: got %h want 204", i, s_haddr); end
      step();
    end
    s_hready = 1'b1;
    #1;
    n_cmp++; if (m1_hready !== 1'b1) begin n_bad++; $display("FAIL ww_done: got %b want 1", m1_hready); end
    step();
    m1_htrans = 2'b00; m1_hwdata = 32'h12345678;
    #1;
    n_cmp++; if (s_hwdata !== 32'h12345678) begin n_bad++; $display("FAIL ww_wdata2: got %h want 12345678", s_hwdata); end
    step();
    idle_inputs();
  endtask

  task automatic test_error();
    do_reset();
    m0_htrans = 2'b10; m0_haddr = 32'h40;
    step();
    m0_htrans = 2'b00; s_hready = 1'b0; s_hresp = 1'b1;
    #1;
    n_cmp++; if (m0_hresp !== 1'b1 || m0_hready !== 1'b0) begin n_bad++; $display("FAIL err_c1: got resp %b rdy %b want 1/0", m0_hresp, m0_hready); end
    n_cmp++; if (m1_hresp !== 1'b0 || m1_hready !== 1'b1) begin n_bad++; $display("FAIL err_m1_c1: got resp %b rdy %b want 0/1", m1_hresp, m1_hready); end
    step();
    s_hready = 1'b1;
    #1;
    n_cmp++; if (m0_hresp !== 1'b1 || m0_hready !== 1'b1) begin n_bad++; $display("FAIL err_c2: got resp %b rdy %b want 1/1", m0_hresp, m0_hready); end
    n_cmp++; if (m1_hresp !== 1'b0) begin n_bad++; $display("FAIL err_m1_c2: got %b want 0", m1_hresp); end
    step();
    s_hresp = 1'b0;
    #1;
    n_cmp++; if (m0_hresp !== 1'b0) begin n_bad++; $display("FAIL err_after: got %b want 0", m0_hresp); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_htrans = 2'b10; m0_haddr = 32'h10;
    m1_htrans = 2'b10; m1_haddr = 32'h20;
    step();
    m1_haddr = 32'h24; s_hrdata = 32'hE1;
    step();
    m0_haddr = 32'h14; s_hrdata = 32'hE0;
    #1;
    n_cmp++; if (dut_rr.pend_1 !== 1'b1) begin n_bad++; $display("FAIL mid_pend_set: got %b want 1", dut_rr.pend_1); end
    #1;
    reset = 1'b1;
    #1;
    n_cmp++; if (dut_rr.pend_0 !== 1'b0 || dut_rr.pend_1 !== 1'b0) begin n_bad++; $display("FAIL mid_pend_clr: got %b%b want 00", dut_rr.pend_1, dut_rr.pend_0); end
    n_cmp++; if (r_s_htrans !== 2'b10 || r_s_haddr !== 32'h24) begin n_bad++; $display("FAIL mid_req: got %h/%h want 2/24", r_s_htrans, r_s_haddr); end
    n_cmp++; if (r_m0_hready !== 1'b0) begin n_bad++; $display("FAIL mid_m0: got %b want 0", r_m0_hready); end
    m0_htrans = 2'b00; m1_htrans = 2'b00;
    #1;
    n_cmp++; if (r_s_htrans !== 2'b00 || s_htrans !== 2'b00) begin n_bad++; $display("FAIL mid_idle: got %h/%h want 0/0", r_s_htrans, s_htrans); end
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_fixed_priority();
    test_round_robin();
    test_wait_write();
    test_error();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
